// File: rtl/spongent_ctrl_pkg.sv
// Shared types and widths for the spongent sequencer.
package spongent_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam int CYCLE_W = 32;

endpackage

// File: rtl/seq_cycle_counter.sv
// Cycle counter with synchronous clear, enable and terminal-count compare.
// Clear and enable compose: clr && en restarts the count at 1, so a phase that
// begins on the next cycle already counts that cycle.
module seq_cycle_counter
   import spongent_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [CYCLE_W-1:0] term,
   output logic [CYCLE_W-1:0] count,
   output logic               hit
);

   logic [CYCLE_W-1:0] count_d;
   logic [CYCLE_W-1:0] count_q;

   // Next count: optional clear, then optional increment.
   always_comb begin
      count_d = clr ? '0 : count_q;
      if (en) begin
         count_d = count_d + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign hit   = (count_q == term);

endmodule

// File: rtl/spongent_seq_ctrl.sv
// Sequencer owning reset/start of one spongent core: accepts a message, holds
// the core in reset for RST_CYCLES, times the run until end_hash or timeout,
// and returns digest, latency and timeout flag over a valid/ready port.
module spongent_seq_ctrl
   import spongent_ctrl_pkg::*;
#(
   parameter int          N              = 88,
   parameter int          DATA_WIDTH     = 64,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_msg,
   output logic                  core_rst,
   output logic [DATA_WIDTH-1:0] core_msg,
   input  logic [N-1:0]          core_hash,
   input  logic                  core_end_hash,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          out_hash,
   output logic [CYCLE_W-1:0]    out_cycles,
   output logic                  out_timeout,
   output logic                  busy
);

   // LOAD counts from 0, so it leaves when the count reaches RST_CYCLES-1.
   localparam logic [CYCLE_W-1:0] LOAD_TERM    = CYCLE_W'(RST_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] TIMEOUT_TERM = CYCLE_W'(TIMEOUT_CYCLES);

   state_t                state_d, state_q;
   logic [DATA_WIDTH-1:0] core_msg_d, core_msg_q;
   logic [N-1:0]          out_hash_d, out_hash_q;
   logic [CYCLE_W-1:0]    out_cycles_d, out_cycles_q;
   logic                  out_timeout_d, out_timeout_q;
   logic                  out_valid_d, out_valid_q;
   logic                  in_ready_d, in_ready_q;
   logic                  core_rst_d, core_rst_q;
   logic                  busy_d, busy_q;

   logic                  cnt_clr;
   logic                  cnt_en;
   logic [CYCLE_W-1:0]    cnt_term;
   logic [CYCLE_W-1:0]    cnt_val;
   logic                  cnt_hit;

   seq_cycle_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .term  (cnt_term),
      .count (cnt_val),
      .hit   (cnt_hit)
   );

   // Next-state, capture and counter control; outputs derive from next state.
   always_comb begin
      state_d       = state_q;
      core_msg_d    = core_msg_q;
      out_hash_d    = out_hash_q;
      out_cycles_d  = out_cycles_q;
      out_timeout_d = out_timeout_q;
      cnt_clr       = 1'b0;
      cnt_en        = 1'b0;
      cnt_term      = (state_q == LOAD) ? LOAD_TERM : TIMEOUT_TERM;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               core_msg_d = in_msg;
               cnt_clr    = 1'b1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            cnt_en = 1'b1;
            if (cnt_hit) begin
               // Restart at 1 so the first RUN cycle reads counter=1.
               cnt_clr = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // end_hash wins over a timeout landing on the same cycle.
            if (core_end_hash) begin
               out_hash_d    = core_hash;
               out_cycles_d  = cnt_val;
               out_timeout_d = 1'b0;
               state_d       = DONE;
            end else if (cnt_hit) begin
               out_hash_d    = '0;
               out_cycles_d  = TIMEOUT_TERM;
               out_timeout_d = 1'b1;
               state_d       = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      core_rst_d  = (state_d != RUN);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         core_msg_q    <= '0;
         out_hash_q    <= '0;
         out_cycles_q  <= '0;
         out_timeout_q <= 1'b0;
         out_valid_q   <= 1'b0;
         in_ready_q    <= 1'b0;
         core_rst_q    <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_msg_q    <= core_msg_d;
         out_hash_q    <= out_hash_d;
         out_cycles_q  <= out_cycles_d;
         out_timeout_q <= out_timeout_d;
         out_valid_q   <= out_valid_d;
         in_ready_q    <= in_ready_d;
         core_rst_q    <= core_rst_d;
         busy_q        <= busy_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign core_rst    = core_rst_q;
   assign core_msg    = core_msg_q;
   assign out_valid   = out_valid_q;
   assign out_hash    = out_hash_q;
   assign out_cycles  = out_cycles_q;
   assign out_timeout = out_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_spongent_seq_ctrl.sv
// Bench for spongent_seq_ctrl: vector table of messages run through a small
// core model, expected results queued on acceptance and compared on delivery.
module tb_spongent_seq_ctrl;

   localparam int N      = 88;
   localparam int DW     = 64;
   localparam int RST_C  = 2;
   localparam int TO_C   = 100;

   typedef struct {
      logic [DW-1:0] msg;
      int            lat;        // RUN cycle at which end_hash rises, 0 = never
      bit            stale;      // end_hash held high while core is in reset
      logic [N-1:0]  hash;
      int            stall;      // cycles out_ready stays low after out_valid
      logic [31:0]   exp_cycles;
      bit            exp_to;
      logic [N-1:0]  exp_hash;
   } vec_t;

   typedef struct {
      logic [N-1:0] hash;
      logic [31:0]  cycles;
      bit           to;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_msg;
   logic          core_rst;
   logic [DW-1:0] core_msg;
   logic [N-1:0]  core_hash;
   logic          core_end_hash;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_hash;
   logic [31:0]   out_cycles;
   logic          out_timeout;
   logic          busy;

   int            n_checks = 0;
   int            n_errors = 0;
   exp_t          sb[$];
   vec_t          vecs[8];

   int            lat_cfg   = 0;
   bit            stale_cfg = 1'b0;
   logic [N-1:0]  hash_cfg  = '0;
   int            run_cnt   = 0;

   spongent_seq_ctrl #(
      .N              (N),
      .DATA_WIDTH     (DW),
      .RST_CYCLES     (RST_C),
      .TIMEOUT_CYCLES (TO_C)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_msg        (in_msg),
      .core_rst      (core_rst),
      .core_msg      (core_msg),
      .core_hash     (core_hash),
      .core_end_hash (core_end_hash),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_hash      (out_hash),
      .out_cycles    (out_cycles),
      .out_timeout   (out_timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   assign core_hash = hash_cfg;

   // Core model: counts cycles with core_rst low, raises end_hash at lat_cfg.
   always @(negedge clk) begin
      if (core_rst !== 1'b0) begin
         run_cnt       = 0;
         core_end_hash = stale_cfg;
      end else begin
         run_cnt       = run_cnt + 1;
         core_end_hash = (lat_cfg != 0) && (run_cnt >= lat_cfg);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_msg(input vec_t v, input string tag);
      int           waitc;
      int           bad;
      exp_t         e;
      logic [N-1:0] snap_hash;
      logic [31:0]  snap_cyc;
      logic         snap_to;
      lat_cfg   = v.lat;
      stale_cfg = v.stale;
      hash_cfg  = v.hash;
      in_msg    = v.msg;
      in_valid  = 1'b1;
      waitc     = 0;
      while (in_ready !== 1'b1 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_accept"}, in_ready, 1'b1);
      if (in_ready !== 1'b1) begin
         in_valid = 1'b0;
         return;
      end
      e.hash   = v.exp_hash;
      e.cycles = v.exp_cycles;
      e.to     = v.exp_to;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_msg   = ~v.msg;
      waitc    = 0;
      bad      = 0;
      while (core_rst === 1'b1 && waitc < 10) begin
         if (core_msg !== v.msg) bad++;
         @(negedge clk);
         waitc++;
      end
      check({tag, "_load_cycles"}, waitc, RST_C);
      waitc = 0;
      while (out_valid !== 1'b1 && waitc < 300) begin
         if (core_msg !== v.msg) bad++;
         @(negedge clk);
         waitc++;
      end
      check({tag, "_done_seen"}, out_valid, 1'b1);
      check({tag, "_msg_stable"}, bad, 0);
      if (out_valid !== 1'b1) begin
         void'(sb.pop_front());
         return;
      end
      snap_hash = out_hash;
      snap_cyc  = out_cycles;
      snap_to   = out_timeout;
      bad       = 0;
      for (int i = 0; i < v.stall; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_hash !== snap_hash || out_cycles !== snap_cyc ||
             out_timeout !== snap_to || in_ready !== 1'b0 || core_rst !== 1'b1) bad++;
      end
      if (v.stall > 0) check({tag, "_bp_stable"}, bad, 0);
      e = sb.pop_front();
      check({tag, "_hash"}, out_hash, e.hash);
      check({tag, "_cycles"}, out_cycles, e.cycles);
      check({tag, "_timeout"}, out_timeout, e.to);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, out_valid, 1'b0);
      check({tag, "_rel_ready"}, in_ready, 1'b1);
      check({tag, "_rel_busy"}, busy, 1'b0);
      check({tag, "_hold_cycles"}, out_cycles, e.cycles);
   endtask

   initial begin
      vecs[0] = '{64'h0123_4567_89AB_CDEF, 45, 1'b0, {11{8'hA5}}, 0, 32'd45, 1'b0, {11{8'hA5}}};
      vecs[1] = '{64'h1111_2222_3333_4444, 12, 1'b0, {11{8'h3C}}, 10, 32'd12, 1'b0, {11{8'h3C}}};
      vecs[2] = '{64'hDEAD_BEEF_0000_0001, 0, 1'b0, {11{8'hA5}}, 0, 32'd100, 1'b1, {N{1'b0}}};
      vecs[3] = '{64'h5555_AAAA_5555_AAAA, 10, 1'b0, {11{8'h5A}}, 0, 32'd10, 1'b0, {11{8'h5A}}};
      vecs[4] = '{64'hFEDC_BA98_7654_3210, 100, 1'b0, {11{8'hC3}}, 0, 32'd100, 1'b0, {11{8'hC3}}};
      vecs[5] = '{64'h0F0F_0F0F_F0F0_F0F0, 30, 1'b1, {11{8'h96}}, 3, 32'd30, 1'b0, {11{8'h96}}};
      vecs[6] = '{64'h0000_0000_0000_0001, 1, 1'b0, {11{8'h81}}, 0, 32'd1, 1'b0, {11{8'h81}}};
      vecs[7] = '{64'h7777_8888_9999_AAAA, 101, 1'b0, {11{8'hE7}}, 0, 32'd100, 1'b1, {N{1'b0}}};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_msg    = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_core_rst", core_rst, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_core_rst", core_rst, 1'b1);
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_core_msg", core_msg, 64'd0);
      check("idle_out_cycles", out_cycles, 32'd0);

      for (int k = 0; k < 8; k++) begin
         run_msg(vecs[k], $sformatf("v%0d", k));
      end

      // Reset while running at counter=20: result is discarded.
      lat_cfg   = 0;
      stale_cfg = 1'b0;
      in_msg    = 64'hCAFE_F00D_1234_5678;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      begin
         int waitc;
         waitc = 0;
         while (core_rst === 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
         end
      end
      check("mid_run_entered", busy && !core_rst, 1'b1);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_core_rst", core_rst, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_cycles", out_cycles, 32'd0);
      check("mid_rst_core_msg", core_msg, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      run_msg('{64'h2468_ACE0_1357_9BDF, 7, 1'b0, {11{8'h42}}, 0, 32'd7, 1'b0, {11{8'h42}}}, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
